// File: rtl/skel_pkg.sv
// Shared types and helpers for the skeletonization front end.
package skel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DONE
  } loader_state_t;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned FRAME_PIXELS = N_DEFAULT * N_DEFAULT;

  function automatic int unsigned frame_pixels(input int unsigned n);
    return n * n;
  endfunction

  // Foreground when the unsigned pixel value reaches the threshold.
  function automatic logic binarize(input int unsigned pix, input int unsigned thresh);
    return pix >= thresh;
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Pixel stream in plus core write port out, as seen by the loader.
interface frame_loader_if #(
  parameter int unsigned pixelWidth = 8
);
  logic                  s_valid;
  logic [pixelWidth-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  we;
  logic [pixelWidth-1:0] data_in;

  modport master (output s_valid, s_data, s_last, input s_ready, we, data_in);
  modport slave  (input s_valid, s_data, s_last, output s_ready, we, data_in);
endinterface

// File: rtl/pixel_binarizer.sv
// Threshold compare with a registered write strobe and pixel.
module pixel_binarizer
  import skel_pkg::*;
#(
  parameter int unsigned pixelWidth = 8,
  parameter int unsigned THRESH     = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [pixelWidth-1:0] pix,
  output logic                  we,
  output logic [pixelWidth-1:0] data_in
);

  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      data_in <= '0;
    end else begin
      we <= valid;
      if (valid) begin
        data_in <= binarize(32'(pix), THRESH) ? {pixelWidth{1'b1}} : '0;
      end
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Loads one binarized N*N frame into the core, then waits out the mask pass.
module frame_loader
  import skel_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned bitSize     = 6,
  parameter int unsigned pixelWidth  = 8,
  parameter int unsigned THRESH      = 128,
  parameter int unsigned PROC_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  frame_loader_if.slave bus,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int unsigned CNT_W     = bitSize + 1;
  localparam int unsigned FRAME_PIX = frame_pixels(N);
  localparam int unsigned SET_W     = (PROC_CYCLES > 1) ? $clog2(PROC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);
  localparam logic [SET_W-1:0] SET_END  = SET_W'(PROC_CYCLES - 1);

  loader_state_t    state, state_next;
  logic [CNT_W-1:0] pix_cnt;
  logic [SET_W-1:0] set_cnt;
  logic             hs;
  logic             at_last;

  assign hs      = bus.s_valid & bus.s_ready;
  assign at_last = (pix_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (hs) begin
          if (at_last)          state_next = ST_SETTLE;
          else if (bus.s_last)  state_next = ST_DONE;
        end
      end
      ST_SETTLE: if (set_cnt == SET_END) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    bus.s_ready = (state == ST_LOAD);
    busy        = (state != ST_IDLE);
    frame_done  = (state == ST_DONE);
  end

  // Pixel counter restarts on every accepted start.
  always_ff @(posedge clk) begin
    if (rst)                              pix_cnt <= '0;
    else if (state == ST_IDLE && start)   pix_cnt <= '0;
    else if (hs)                          pix_cnt <= pix_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_SETTLE) set_cnt <= '0;
    else                           set_cnt <= set_cnt + SET_W'(1);
  end

  // Sticky until the next start: short frame or missing end marker.
  always_ff @(posedge clk) begin
    if (rst)                                 frame_err <= 1'b0;
    else if (state == ST_IDLE && start)      frame_err <= 1'b0;
    else if (hs && (at_last != bus.s_last))  frame_err <= 1'b1;
  end

  pixel_binarizer #(
    .pixelWidth (pixelWidth),
    .THRESH     (THRESH)
  ) u_bin (
    .clk     (clk),
    .rst     (rst),
    .valid   (hs),
    .pix     (bus.s_data),
    .we      (bus.we),
    .data_in (bus.data_in)
  );

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: write data/order, latency, done timing, errors.
module tb_frame_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, frame_done, frame_err;

  frame_loader_if #(.pixelWidth(8)) bus ();

  frame_loader #(
    .N(8), .bitSize(6), .pixelWidth(8), .THRESH(128), .PROC_CYCLES(256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  int         ncyc = 0, wr_cnt = 0, done_cnt = 0;
  int         last_hs = 0, done_at = 0, busy_fall = 0;
  int         cur_run = 0, max_run = 0;
  logic       exp_we = 1'b0, prev_busy = 1'b0;
  logic [7:0] sb[$];

  function automatic logic [7:0] model_bin(input logic [7:0] d);
    return (d >= 8'd128) ? 8'hFF : 8'h00;
  endfunction

  always @(negedge clk) begin
    logic hs_eff;
    ncyc++;
    if (bus.we || exp_we) check("we_latency", 32'(bus.we), 32'(exp_we));
    if (bus.we) begin
      wr_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (sb.size() == 0) check("we_unexpected", 1, 0);
      else                check("data_in", 32'(bus.data_in), 32'(sb.pop_front()));
    end else begin
      cur_run = 0;
    end
    if (frame_done) begin
      done_cnt++;
      done_at = ncyc;
    end
    if (prev_busy && !busy) busy_fall = ncyc;
    prev_busy = busy;
    hs_eff = bus.s_valid & bus.s_ready & ~rst;
    exp_we = hs_eff;
    if (hs_eff) begin
      sb.push_back(model_bin(bus.s_data));
      last_hs = ncyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame();
    bus.s_valid = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ready_after_start", 32'(bus.s_ready), 1);
    check("err_cleared", 32'(frame_err), 0);
  endtask

  task automatic send_frame(input int n, input int last_at, input int max_gap,
                            input int budget, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.s_valid = 1'b0;
      tick(gap);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i * 4);
      bus.s_last  = (i + 1 == last_at);
      for (int k = 0; k < budget; k++) begin
        if (bus.s_ready) begin
          tick(1);
          acc++;
          break;
        end else begin
          tick(1);
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != base) break;
      tick(1);
    end
    check("done_seen", 32'(done_cnt - base), 1);
    tick(3);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, w0, d0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_we", 32'(bus.we), 0);
    check("rst_data_in", 32'(bus.data_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);

    // Nominal frame
    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(64, 64, 0, 20, acc);
    check("nom_accepted", 32'(acc), 64);
    wait_done(d0, 400);
    check("nom_writes", 32'(wr_cnt - w0), 64);
    check("nom_consecutive", 32'(max_run), 64);
    check("nom_done_delay", 32'(done_at - last_hs), 257);
    check("nom_busy_fall", 32'(busy_fall - last_hs), 258);
    check("nom_err", 32'(frame_err), 0);
    check("nom_busy_idle", 32'(busy), 0);

    // Throttled input
    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(64, 64, 5, 20, acc);
    check("thr_accepted", 32'(acc), 64);
    wait_done(d0, 400);
    check("thr_writes", 32'(wr_cnt - w0), 64);
    check("thr_done_delay", 32'(done_at - last_hs), 257);
    check("thr_err", 32'(frame_err), 0);

    // Early s_last on beat 10
    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(10, 10, 0, 20, acc);
    wait_done(d0, 50);
    check("early_writes", 32'(wr_cnt - w0), 10);
    check("early_done_delay", 32'(done_at - last_hs), 1);
    check("early_busy_fall", 32'(busy_fall - last_hs), 2);
    check("early_err", 32'(frame_err), 1);

    // Missing s_last: 70 beats offered, only 64 taken
    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(70, 0, 0, 3, acc);
    check("miss_accepted", 32'(acc), 64);
    check("miss_busy_settle", 32'(busy), 1);
    wait_done(d0, 400);
    check("miss_writes", 32'(wr_cnt - w0), 64);
    check("miss_done_delay", 32'(done_at - last_hs), 257);
    check("miss_err_sticky", 32'(frame_err), 1);

    // start while busy in LOAD and SETTLE
    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(20, 0, 0, 20, acc);
    start = 1'b1; tick(1); start = 1'b0;
    check("sb_ready_in_load", 32'(bus.s_ready), 1);
    send_frame(44, 44, 0, 20, acc);
    check("sb_accepted", 32'(acc), 44);
    tick(10);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done(d0, 400);
    check("sb_done_delay", 32'(done_at - last_hs), 257);
    check("sb_busy_fall", 32'(busy_fall - last_hs), 258);
    check("sb_writes", 32'(wr_cnt - w0), 64);
    check("sb_err", 32'(frame_err), 0);
    tick(20);
    check("sb_single_done", 32'(done_cnt - d0), 1);
    check("sb_idle", 32'(busy), 0);

    // Reset in the middle of LOAD, with a beat pending
    w0 = wr_cnt;
    start_frame();
    send_frame(30, 0, 0, 20, acc);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd200;
    rst = 1'b1;
    tick(1);
    check("mrst_we", 32'(bus.we), 0);
    check("mrst_data_in", 32'(bus.data_in), 0);
    check("mrst_s_ready", 32'(bus.s_ready), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    tick(2);
    check("mrst_writes", 32'(wr_cnt - w0), 30);

    w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    send_frame(64, 64, 0, 20, acc);
    check("post_accepted", 32'(acc), 64);
    wait_done(d0, 400);
    check("post_writes", 32'(wr_cnt - w0), 64);
    check("post_done_delay", 32'(done_at - last_hs), 257);
    check("post_err", 32'(frame_err), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
